// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces the rows and emits
// one key_pressed strobe plus a 4-bit key code per accepted press.
module keypad_scanner #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_pressed,
    output logic [3:0] keypad_out,
    output logic       key_held
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);
    // one nibble per key, indexed by {row, col}
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD} state_t;

    state_t          state, state_nx;
    logic [3:0]      sync1, rs;
    logic [SW-1:0]   slot;
    logic [1:0]      col, col_nx, row_lat, row_nx, win;
    logic [DW-1:0]   cnt, cnt_nx, cnt_inc;
    logic            sample, any_low, done, accept, key_held_nx;
    logic [3:0]      keypad_out_nx;

    assign col_out = ~(4'b0001 << col);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= '0;
            rs          <= '0;
            slot        <= '0;
            state       <= SCAN;
            col         <= '0;
            row_lat     <= '0;
            cnt         <= '0;
            key_pressed <= 1'b0;
            keypad_out  <= 4'h0;
            key_held    <= 1'b0;
        end else begin
            sync1       <= row_in;
            rs          <= sync1;
            slot        <= sample ? '0 : slot + 1'b1;
            state       <= state_nx;
            col         <= col_nx;
            row_lat     <= row_nx;
            cnt         <= cnt_nx;
            key_pressed <= accept;
            keypad_out  <= keypad_out_nx;
            key_held    <= key_held_nx;
        end
    end

    // cnt is zero on every entry to SCAN, so cnt_inc there is the first sample
    always_comb begin
        sample        = slot == SW'(SCAN_DIV - 1);
        any_low       = rs != 4'hF;
        win           = !rs[0] ? 2'd0 : !rs[1] ? 2'd1 : !rs[2] ? 2'd2 : 2'd3;
        cnt_inc       = cnt + 1'b1;
        done          = cnt_inc == DW'(DEBOUNCE_CNT);
        state_nx      = state;
        col_nx        = col;
        row_nx        = row_lat;
        cnt_nx        = cnt;
        accept        = 1'b0;
        key_held_nx   = key_held;
        keypad_out_nx = keypad_out;
        if (sample) begin
            case (state)
                SCAN: begin
                    if (any_low) begin
                        row_nx   = win;
                        cnt_nx   = cnt_inc;
                        state_nx = PRESS_DB;
                        accept   = done;
                    end else begin
                        col_nx = col + 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (any_low && win == row_lat) begin
                        cnt_nx = cnt_inc;
                        accept = done;
                    end else begin
                        cnt_nx   = '0;
                        state_nx = SCAN;
                        col_nx   = col + 1'b1;
                    end
                end
                HELD: begin
                    if (!rs[row_lat]) begin
                        cnt_nx = '0;
                    end else if (done) begin
                        cnt_nx      = '0;
                        key_held_nx = 1'b0;
                        col_nx      = col + 1'b1;
                        state_nx    = SCAN;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                default: state_nx = SCAN;
            endcase
        end
        if (accept) begin
            state_nx      = HELD;
            cnt_nx        = '0;
            key_held_nx   = 1'b1;
            keypad_out_nx = KEY_MAP[{row_nx, col, 2'b00} +: 4];
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of keypad_scanner against a behavioural
// keypad matrix (SCAN_DIV=4, DEBOUNCE_CNT=3).
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_in, col_out, keypad_out;
    logic        key_pressed, key_held;
    logic [15:0] keys = '0;
    int          checks = 0, failures = 0, strobes = 0, base = 0;
    logic [3:0]  scan_seq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
        .key_pressed(key_pressed), .keypad_out(keypad_out), .key_held(key_held)
    );

    // keys[r*4+c] pressed shorts row r to column c
    for (genvar r = 0; r < 4; r++) begin : g_row
        assign row_in[r] = ~|(keys[4*r +: 4] & ~col_out);
    end

    always @(posedge clk) if (key_pressed) strobes <= strobes + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strobe(input string tag, input int max_cyc);
        int n = 0;
        while (key_pressed !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, key_pressed, 1);
    endtask

    task automatic wait_release(input string tag);
        int n = 0;
        while (key_held !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, key_held, 0);
    endtask

    task automatic wait_col(input string tag, input logic [3:0] target);
        int n = 0;
        while (col_out == target && n < 20) begin
            @(negedge clk);
            n++;
        end
        while (col_out != target && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, col_out, target);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_col", col_out, 4'b1110);
        check("rst_strobe", key_pressed, 0);
        check("rst_code", keypad_out, 4'h0);
        check("rst_held", key_held, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(4);
            check("scan_step", col_out, scan_seq[i]);
        end
        // clean "5": column 1 entered 4 cycles later, then 3 samples
        keys[5] = 1'b1;
        cyc(15);
        check("p5_early", key_pressed, 0);
        cyc(1);
        check("p5_strobe", key_pressed, 1);
        check("p5_code", keypad_out, 4'h5);
        check("p5_held", key_held, 1);
        cyc(1);
        check("p5_single", key_pressed, 0);
        cyc(83);
        check("p5_still_held", key_held, 1);
        check("p5_no_repeat", strobes, 1);
        keys[5] = 1'b0;
        cyc(11);
        check("p5_rel_early", key_held, 1);
        cyc(1);
        check("p5_released", key_held, 0);
        check("p5_rel_col", col_out, 4'b1011);
        check("p5_code_kept", keypad_out, 4'h5);
        check("p5_count", strobes, 1);
        // bouncy "#"
        base = strobes;
        for (int i = 0; i < 20; i++) begin
            keys[14] = ((i / 3) % 2) == 0;
            cyc(1);
        end
        keys[14] = 1'b1;
        check("hash_bounce", strobes, base);
        wait_strobe("hash_strobe", 40);
        check("hash_code", keypad_out, 4'hF);
        cyc(30);
        check("hash_count", strobes, base + 1);
        keys[14] = 1'b0;
        wait_release("hash_release");
        check("hash_code_kept", keypad_out, 4'hF);
        // one-slot glitch on "A"
        base = strobes;
        wait_col("glitch_align", 4'b0111);
        keys[3] = 1'b1;
        cyc(4);
        check("glitch_freeze", col_out, 4'b0111);
        keys[3] = 1'b0;
        cyc(4);
        check("glitch_resume", col_out, 4'b1110);
        check("glitch_none", strobes, base);
        check("glitch_code", keypad_out, 4'hF);
        // "1" and "7" together, then "D" while held
        base = strobes;
        keys[0] = 1'b1;
        keys[8] = 1'b1;
        wait_strobe("mk_strobe", 40);
        check("mk_code", keypad_out, 4'h1);
        keys[15] = 1'b1;
        cyc(40);
        check("mk_d_ignored", strobes, base + 1);
        check("mk_held", key_held, 1);
        keys[0] = 1'b0;
        keys[8] = 1'b0;
        wait_strobe("mk_d_strobe", 80);
        check("mk_d_code", keypad_out, 4'hD);
        cyc(2);
        check("mk_count", strobes, base + 2);
        keys[15] = 1'b0;
        wait_release("mk_d_release");
        // reset after two samples of "0"
        base = strobes;
        wait_col("rst0_align", 4'b1110);
        keys[13] = 1'b1;
        cyc(13);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst0_strobe", key_pressed, 0);
        check("rst0_held", key_held, 0);
        check("rst0_code", keypad_out, 4'h0);
        check("rst0_col", col_out, 4'b1110);
        check("rst0_none", strobes, base);
        cyc(15);
        check("rst0_early", key_pressed, 0);
        cyc(1);
        check("rst0_strobe_after", key_pressed, 1);
        check("rst0_code_after", keypad_out, 4'h0);
        check("rst0_held_after", key_held, 1);
        keys[13] = 1'b0;
        wait_release("rst0_release");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Matrix-keypad front end that sits directly upstream of the calculator core.
- Scans a 4x4 active-low keypad, synchronises and debounces the row inputs, and encodes the pressed key into a 4-bit code.
- Emits exactly one single-cycle key_pressed strobe per debounced press; this strobe and the code feed the calculator's key_pressed / keypad_out inputs.
- The top level routes the column drives to dedicated outputs and the rows from dedicated inputs.

Parameters:
- SCAN_DIV, 16: clock cycles per column slot; legal range 4..65535.
- DEBOUNCE_CNT, 4: consecutive matching samples (one per slot) needed to accept a press or a release; legal range 1..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- row_in  input  4  keypad rows, active-low (external pull-ups), asynchronous to clk
- col_out  output  4  column drive, active-low one-hot; exactly one bit low at all times
- key_pressed  output  1  one-cycle strobe marking a debounced new press
- keypad_out  output  4  code of the last accepted key; stable between strobes
- key_held  output  1  high while an accepted key is still held

Behaviour:
- Reset values (one clock): state=SCAN, col_out=4'b1110, key_pressed=0, keypad_out=4'h0, key_held=0; slot counter, debounce counter and synchroniser flops all cleared. A reset mid-operation aborts any press in progress and emits no strobe.
- Synchroniser: row_in passes through a 2-flop synchroniser. All logic uses only the synchronised value rs.
- Slot timer: counts 0..SCAN_DIV-1 and wraps. The "sample point" is the cycle where the count = SCAN_DIV-1. This gives at least 2 settle cycles after a column change.
- Key map, row r / column c:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: *,0,#,D
  - Codes: digits map to their own value; A=0xA, B=0xB, C=0xC, D=0xD, *=0xE, #=0xF.
- Row priority: if several rows are low in the driven column, the lowest row index wins. There is no rollover; other columns are not examined while a key is being debounced or held.
- SCAN:
  - At each sample point, if rs==4'hF, rotate col_out to the next column (0->1->2->3->0).
  - Otherwise latch row/column, set debounce count=1, and go to PRESS_DB. The column does not rotate.
  - If DEBOUNCE_CNT=1, skip PRESS_DB and accept immediately (see acceptance below).
- PRESS_DB (column frozen), at each sample point:
  - Same winning row still low: count+1.
  - Anything else: clear count, return to SCAN and rotate to the next column.
  - When the count reaches DEBOUNCE_CNT, accept the press.
- Press acceptance, in the cycle after the accepting sample point:
  - key_pressed=1 for that cycle only.
  - keypad_out updates to the code in that same cycle.
  - key_held=1; state becomes HELD.
- HELD (column frozen, key_held=1), at each sample point:
  - Latched row high: release count+1.
  - Latched row low: release count=0.
  - When the release count reaches DEBOUNCE_CNT: key_held=0, col_out rotates to the next column, state becomes SCAN.
  - The release emits no strobe. keypad_out keeps its value until the next accepted press.
- A key held indefinitely produces no repeat strobes. Pressing a second key in another column while one is held is ignored.
- Worst-case press latency from a stable row change: 2 sync cycles + up to 4*SCAN_DIV scan time + (DEBOUNCE_CNT-1)*SCAN_DIV + 1 cycle.
- Counter widths are sized from the parameters; no counter wraps past its terminal value.

Test Plan (bench uses SCAN_DIV=4, DEBOUNCE_CNT=3, with a behavioural keypad model):
- Reset check: hold rst_n=0 for 3 cycles then release -> col_out=1110, key_pressed=0, keypad_out=0, key_held=0; col_out steps 1110->1101->1011->0111->1110, one step every 4 cycles.
- Clean press of "5" (r1,c1), held 100 cycles then released -> exactly one key_pressed pulse with keypad_out=0x5 in that cycle; key_held=1 until 3 clean release samples; keypad_out stays 0x5 afterwards.
- Bouncy press of "#" (r3,c2), toggling every 3 cycles for 20 cycles, then stable -> no strobe during bounce; exactly one strobe with keypad_out=0xF after 3 stable samples.
- Glitch rejection: "A" (r0,c3) low for only 1 slot -> no strobe; keypad_out unchanged; scanning resumes at column 0.
- Multi-key: "1" and "7" pressed together (column 0, rows 0 and 2) -> one strobe with code 0x1. Then press "D" while still holding -> no strobe until both "1" and "7" are released and "D" is rescanned, then code 0xD.
- Reset mid-debounce: press "0" and assert rst_n=0 after 2 samples -> no strobe; outputs at reset values. Keep holding after reset release -> strobe with code 0x0 after a full debounce.
